// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the sigma-delta audio path (ADC decimator and DAC).
//   cic_width()  : internal CIC register width for a given decimation log2
//   sample_t     : excess-2^MSBI sample word at the default 16-bit width
//   MIDSCALE     : zero-signal code of sample_t
// -----------------------------------------------------------------------------
package sd_pkg;

    localparam int MSBI_DEFAULT = 15;

    typedef logic [MSBI_DEFAULT:0] sample_t;

    localparam sample_t MIDSCALE = sample_t'(1) << MSBI_DEFAULT;

    // A sinc2 stage with ratio 2^d has DC gain 2^(2d); one extra bit holds
    // the full-scale value 2^(2d) itself before it is saturated.
    function automatic int cic_width(input int decim_log2);
        return 2 * decim_log2 + 1;
    endfunction

endpackage

// File: rtl/cic2_decimator.sv
// -----------------------------------------------------------------------------
// cic2_decimator
// Second-order CIC (sinc2) decimator for a 1-bit sigma-delta stream.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   s       : synchronized bitstream bit
//   sample  : decimated sample, excess-2^MSBI, held between strobes
//   valid   : one-cycle strobe, sample is updated in the same cycle
// DECIM_LOG2 must satisfy 2*DECIM_LOG2 >= MSBI+1.
// -----------------------------------------------------------------------------
module cic2_decimator
    import sd_pkg::*;
#(
    parameter int MSBI       = 15,
    parameter int DECIM_LOG2 = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s,
    output logic [MSBI:0]   sample,
    output logic            valid
);

    localparam int W = cic_width(DECIM_LOG2);

    localparam logic [MSBI:0] MID      = {1'b1, {MSBI{1'b0}}};
    localparam logic [W-1:0]  SAT_HIT  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  SAT_MAX  = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0]            i1;
    logic [W-1:0]            i2;
    logic [W-1:0]            i2d;
    logic [W-1:0]            c1d;
    logic [W-1:0]            c2_q;
    logic [W-1:0]            c1;
    logic [W-1:0]            c2;
    logic [W-1:0]            c2_sat;
    logic [DECIM_LOG2-1:0]   cnt;
    logic [1:0]              warm;
    logic                    fire;
    logic                    tc;
    logic                    c2_sat_unused;

    assign tc = (cnt == {DECIM_LOG2{1'b1}});

    // Comb arithmetic wraps modulo 2^W on purpose; only the differences matter.
    assign c1 = i2 - i2d;
    assign c2 = c1 - c1d;

    // Full-scale input lands exactly on 2^(W-1), one past the top code.
    assign c2_sat        = (c2_q == SAT_HIT) ? SAT_MAX : c2_q;
    assign c2_sat_unused = c2_sat[W-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i1     <= '0;
            i2     <= '0;
            i2d    <= '0;
            c1d    <= '0;
            c2_q   <= '0;
            cnt    <= '0;
            warm   <= '0;
            fire   <= 1'b0;
            sample <= MID;
            valid  <= 1'b0;
        end else begin
            i1    <= i1 + {{(W-1){1'b0}}, s};
            i2    <= i2 + i1;
            cnt   <= cnt + 1'b1;
            fire  <= 1'b0;
            valid <= fire;
            if (fire) begin
                sample <= c2_sat[W-2 -: MSBI+1];
            end
            if (tc) begin
                i2d  <= i2;
                c1d  <= c1;
                c2_q <= c2;
                // The first two comb outputs still carry the start-up transient
                // of the delay registers, so they are dropped.
                if (warm != 2'd2) begin
                    warm <= warm + 2'd1;
                end else begin
                    fire <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sigma_delta_adc.sv
// -----------------------------------------------------------------------------
// sigma_delta_adc
// First-order sigma-delta ADC front end: comparator synchronizer, 1-bit
// feedback to the external RC integrator, and a sinc2 decimator.
//   CLK     : clock, rising edge
//   RESET_N : synchronous active-low reset
//   ADCin   : raw comparator output (asynchronous)
//   FB      : registered feedback bit, optionally inverted by INV
//   SAMPLE  : decimated sample, excess-2^MSBI (same code as the DAC input)
//   VALID   : one-cycle strobe accompanying each SAMPLE update
// -----------------------------------------------------------------------------
module sigma_delta_adc
    import sd_pkg::*;
#(
    parameter int   MSBI       = 15,
    parameter int   DECIM_LOG2 = 8,
    parameter logic INV        = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            ADCin,
    output logic            FB,
    output logic [MSBI:0]   SAMPLE,
    output logic            VALID
);

    logic sync1;
    logic sync2;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            FB    <= INV;
        end else begin
            sync1 <= ADCin;
            sync2 <= sync1;
            FB    <= sync2 ^ INV;
        end
    end

    cic2_decimator #(
        .MSBI       (MSBI),
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_cic (
        .clk     (CLK),
        .reset_n (RESET_N),
        .s       (sync2),
        .sample  (SAMPLE),
        .valid   (VALID)
    );

endmodule

// File: tb/tb_sigma_delta_adc.sv
// -----------------------------------------------------------------------------
// tb_sigma_delta_adc
// Drives comparator patterns into sigma_delta_adc and compares FB, VALID and
// SAMPLE every cycle against a sinc2 model built as a triangle-weighted sum
// over the recorded input bits.
// -----------------------------------------------------------------------------
module tb_sigma_delta_adc;

    localparam int R    = 256;
    localparam int HMAX = 16384;

    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ADCin   = 1'b0;
    logic        FB;
    logic [15:0] SAMPLE;
    logic        VALID;

    sigma_delta_adc #(
        .MSBI       (15),
        .DECIM_LOG2 (8),
        .INV        (1'b1)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .ADCin   (ADCin),
        .FB      (FB),
        .SAMPLE  (SAMPLE),
        .VALID   (VALID)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // model state: t = edges since the reset edge, a_hist[k] = ADCin seen at edge k
    int          t = 0;
    bit          a_hist [HMAX];
    logic [15:0] exp_sample = 16'h8000;
    bit          exp_valid  = 1'b0;
    int          first_valid = 0;
    int          pat_k = 0;
    int          dens  = 128;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    // bitstream seen by the loop after edge i (two synchronizer stages)
    function automatic int s_at(input int i);
        if (i < 2) return 0;
        return int'(a_hist[i-1]);
    endfunction

    function automatic int tri_w(input int u);
        return (u <= R) ? u : 2 * R - u;
    endfunction

    // sinc2 output for the comb evaluated at edge e
    function automatic int sinc2_at(input int e);
        int acc = 0;
        for (int i = e - 2 - 2 * R; i <= e - 2; i++) begin
            if (i >= 0) acc += s_at(i) * tri_w(e - 2 - i);
        end
        return acc;
    endfunction

    function automatic bit gen_bit(input int mode, input int k);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return bit'(k % 2);
            3:       return (k % 4) == 0;
            4:       return (k % 4) != 3;
            default: return $urandom_range(255, 0) < dens;
        endcase
    endfunction

    task automatic step(input bit nxt);
        int v;
        ADCin = nxt;
        a_hist[(t + 1) % HMAX] = nxt;
        @(posedge CLK);
        t++;
        if (t >= 3 * R + 1 && (t % R) == 1) begin
            exp_valid = 1'b1;
            v = sinc2_at(t - 1);
            if (v == 65536) v = 65535;
            exp_sample = 16'(v);
        end else begin
            exp_valid = 1'b0;
        end
        @(negedge CLK);
        chk("fb",     FB,     (t >= 3 ? int'(a_hist[t-2]) : 0) ^ 1);
        chk("valid",  VALID,  exp_valid);
        chk("sample", SAMPLE, exp_sample);
        if (VALID && first_valid == 0) first_valid = t;
    endtask

    task automatic run(input int mode, input int n);
        for (int i = 0; i < n; i++) begin
            step(gen_bit(mode, pat_k));
            pat_k++;
        end
    endtask

    task automatic do_reset(input int n);
        RESET_N = 1'b0;
        ADCin   = 1'($urandom_range(1, 0));
        for (int i = 0; i < n; i++) @(posedge CLK);
        @(negedge CLK);
        t           = 0;
        exp_sample  = 16'h8000;
        exp_valid   = 1'b0;
        first_valid = 0;
        chk("rst_fb",     FB,     1);
        chk("rst_sample", SAMPLE, 16'h8000);
        chk("rst_valid",  VALID,  0);
        RESET_N = 1'b1;
    endtask

    initial begin
        @(negedge CLK);
        do_reset(3);

        // constant 0, then constant 1, then fixed-density patterns
        run(0, 3 * R + 1 + 2 * R);
        chk("first_valid_edge", first_valid, 3 * R + 1);
        chk("zero_sample", SAMPLE, 16'h0000);
        run(1, 5 * R);
        chk("full_scale_sample", SAMPLE, 16'hFFFF);
        run(2, 4 * R);
        chk("half_sample", SAMPLE, 16'h8000);
        run(3, 4 * R);
        chk("quarter_sample", SAMPLE, 16'h4000);
        run(4, 4 * R);
        chk("three_quarter_sample", SAMPLE, 16'hC000);

        // step from silence to half density after a fresh reset
        @(negedge CLK);
        do_reset(1);
        run(0, 4 * R + 37);
        run(2, 5 * R);
        chk("step_final_sample", SAMPLE, 16'h8000);

        // reset one cycle mid-frame, warm-up restarts
        do_reset(1);
        run(5, 3 * R + 1);
        chk("first_valid_after_midreset", first_valid, 3 * R + 1);
        run(5, 100);

        // reset with a comb result in flight: no strobe may escape
        do_reset(1);
        run(5, 3 * R);
        do_reset(1);

        // reset landing on a terminal count, counter restarts from zero
        run(5, R - 1);
        do_reset(1);
        run(5, 3 * R + 1);
        chk("first_valid_after_tc_reset", first_valid, 3 * R + 1);

        // random densities
        for (int j = 0; j < 4; j++) begin
            dens = $urandom_range(256, 0);
            run(5, 3 * R);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
